// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and halt controller for a classic five-stage pipeline. It decides,
// every cycle, which pipeline registers may load and which get squashed.
// It also sequences the halt instruction from MEM through a one-cycle drain
// into a halted state, and keeps two performance counters.
//
// Parameters
//   CNT_W          width of the performance counters
//
// Ports
//   CLK            sole clock, rising-edge
//   RST            asynchronous active-high reset
//   ihit           instruction fetch completed this cycle
//   dhit           data access completed this cycle
//   Rs_IF_ID       source register (rs) of the instruction in decode
//   Rt_IF_ID       source register (rt) of the instruction in decode
//   dREN_ID_EX     load instruction sitting in EX
//   Rt_ID_EX       destination register of that load
//   dREN_EX_MEM    data read in MEM
//   dWEN_EX_MEM    data write in MEM
//   branch_taken_EX    control-flow redirect resolved in EX
//   halt_EX_MEM    halt instruction in MEM
//   enable_*       pipeline register / PC load enables
//   flush_*        pipeline register squash controls
//   halt           CPU halted
//   cycle_cnt      cycles spent not halted (wraps)
//   stall_cnt      RUN cycles with the PC held (saturates)
//   state          FSM state: RUN=0, DRAIN=1, HALTED=2
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       Rs_IF_ID,
    input  logic [4:0]       Rt_IF_ID,
    input  logic             dREN_ID_EX,
    input  logic [4:0]       Rt_ID_EX,
    input  logic             dREN_EX_MEM,
    input  logic             dWEN_EX_MEM,
    input  logic             branch_taken_EX,
    input  logic             halt_EX_MEM,
    output logic             enable_PC,
    output logic             enable_IF_ID,
    output logic             flush_IF_ID,
    output logic             enable_ID_EX,
    output logic             flush_ID_EX,
    output logic             enable_EX_MEM,
    output logic             enable_MEM_WB,
    output logic             halt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        HALTED  = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t cur_state;
    state_t next_state;

    logic mem_op;
    logic mem_stall;
    logic load_use;

    assign state = cur_state;

    // A data access in MEM that has not completed freezes the whole pipe.
    // A load in EX whose destination feeds the decode instruction forces a
    // one-cycle bubble; loads to $0 never create a dependency.
    assign mem_op    = dREN_EX_MEM | dWEN_EX_MEM;
    assign mem_stall = mem_op & ~dhit;
    assign load_use  = dREN_ID_EX & (Rt_ID_EX != 5'd0) &
                       ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));

    // Pipeline control decode. Checks are in priority order and the first
    // match wins. A taken branch outranks a load-use stall because the
    // instruction in decode is wrong-path and gets squashed anyway. The PC
    // loads the branch target even if the current fetch missed. The
    // unreachable encoding decodes like RUN so the pipe is never wedged.
    // Reset forces cur_state to RUN asynchronously, so the RUN decode
    // applies during reset without a separate term.
    always_comb begin
        enable_PC     = 1'b0;
        enable_IF_ID  = 1'b0;
        flush_IF_ID   = 1'b0;
        enable_ID_EX  = 1'b0;
        flush_ID_EX   = 1'b0;
        enable_EX_MEM = 1'b0;
        enable_MEM_WB = 1'b0;
        halt          = 1'b0;
        case (cur_state)
            HALTED: begin
                halt = 1'b1;
            end
            DRAIN: begin
                enable_MEM_WB = 1'b1;
            end
            default: begin
                if (mem_stall) begin
                    enable_PC = 1'b0;
                end else if (branch_taken_EX) begin
                    enable_PC     = 1'b1;
                    enable_IF_ID  = 1'b1;
                    flush_IF_ID   = 1'b1;
                    enable_ID_EX  = 1'b1;
                    flush_ID_EX   = 1'b1;
                    enable_EX_MEM = 1'b1;
                    enable_MEM_WB = 1'b1;
                end else if (load_use) begin
                    enable_ID_EX  = 1'b1;
                    flush_ID_EX   = 1'b1;
                    enable_EX_MEM = 1'b1;
                    enable_MEM_WB = 1'b1;
                end else if (!ihit) begin
                    enable_IF_ID  = 1'b1;
                    flush_IF_ID   = 1'b1;
                    enable_ID_EX  = 1'b1;
                    enable_EX_MEM = 1'b1;
                    enable_MEM_WB = 1'b1;
                end else begin
                    enable_PC     = 1'b1;
                    enable_IF_ID  = 1'b1;
                    enable_ID_EX  = 1'b1;
                    enable_EX_MEM = 1'b1;
                    enable_MEM_WB = 1'b1;
                end
            end
        endcase
    end

    // Halt sequencing. A halt in MEM may only leave RUN once its own memory
    // access (if any) is done. DRAIN gives the halt one cycle to retire
    // through MEM/WB, then the core parks in HALTED until reset.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            RUN:     next_state = (halt_EX_MEM && !mem_stall) ? DRAIN : RUN;
            DRAIN:   next_state = HALTED;
            HALTED:  next_state = HALTED;
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur_state <= RUN;
        end else begin
            cur_state <= next_state;
        end
    end

    // Performance counters. cycle_cnt counts every non-halted cycle and wraps.
    // stall_cnt counts RUN cycles in which the PC was held. It sticks at
    // all-ones so a long run never reports a misleadingly small figure.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (cur_state != HALTED) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if ((cur_state == RUN) && !enable_PC && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters SHALL be: CNT_W, 32, width of performance counters.
REQ-002 Port CLK, input, 1: sole clock, all state updates on rising edge.
REQ-003 Port RST, input, 1: asynchronous, active-high reset.
REQ-004 Port ihit, input, 1: instruction fetch completed this cycle.
REQ-005 Port dhit, input, 1: data access completed this cycle.
REQ-006 Ports Rs_IF_ID, Rt_IF_ID, input, 5 each: source registers of instruction in decode.
REQ-007 Ports dREN_ID_EX, input, 1, and Rt_ID_EX, input, 5: load in EX and its destination.
REQ-008 Ports dREN_EX_MEM, dWEN_EX_MEM, input, 1 each: data access in MEM.
REQ-009 Ports branch_taken_EX, input, 1: control-flow redirect resolved in EX.
REQ-010 Port halt_EX_MEM, input, 1: halt instruction in MEM.
REQ-011 Ports enable_PC, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX, enable_EX_MEM, enable_MEM_WB, output, 1 each: pipeline register controls.
REQ-012 Port halt, output, 1: CPU halted.
REQ-013 Ports cycle_cnt, stall_cnt, output, CNT_W each: performance counters.
REQ-014 Port state, output, 2: FSM state, RUN=0, DRAIN=1, HALTED=2.

Function
REQ-015 Derived: mem_op = dREN_EX_MEM | dWEN_EX_MEM; mem_stall = mem_op & ~dhit.
REQ-016 Derived: load_use = dREN_ID_EX & (Rt_ID_EX != 0) & ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID)).
REQ-017 Outputs SHALL be combinational from state and inputs, priority order REQ-018..REQ-023 (first match wins).
REQ-018 HALTED: all enables 0, all flushes 0, halt=1.
REQ-019 DRAIN: enable_MEM_WB=1, all other enables and flushes 0, halt=0.
REQ-020 RUN with mem_stall: all enables 0, all flushes 0 (full freeze).
REQ-021 RUN with branch_taken_EX: all enables 1, flush_IF_ID=1, flush_ID_EX=1 (PC loads target even when ihit=0).
REQ-022 RUN with load_use: enable_PC=0, enable_IF_ID=0, flush_IF_ID=0, enable_ID_EX=1, flush_ID_EX=1, EX_MEM/MEM_WB enabled.
REQ-023 RUN with ihit=0: enable_PC=0, enable_IF_ID=1, flush_IF_ID=1 (bubble), ID_EX/EX_MEM/MEM_WB enabled, flush_ID_EX=0.
REQ-024 RUN otherwise: all enables 1, all flushes 0.
REQ-025 Any flush output at 1 SHALL coincide with its enable at 1.
REQ-026 Transitions: RUN->DRAIN when halt_EX_MEM & ~mem_stall; DRAIN->HALTED unconditionally; HALTED holds until RST; RUN otherwise holds.
REQ-027 cycle_cnt SHALL increment every cycle while state != HALTED, wrapping modulo 2^CNT_W.
REQ-028 stall_cnt SHALL increment in RUN when enable_PC=0, saturating at all-ones (no wrap).
REQ-029 Simultaneous branch_taken_EX and load_use SHALL follow branch (REQ-021); simultaneous halt_EX_MEM and mem_stall SHALL stay in RUN frozen until dhit.
REQ-030 Encoding 3 SHALL be unreachable; if entered, next state SHALL be RUN.

Reset
REQ-031 RST=1 SHALL immediately force state=RUN, cycle_cnt=0, stall_cnt=0, independent of CLK.
REQ-032 During RST=1 outputs SHALL follow RUN decoding of current inputs; halt=0.
REQ-033 RST asserted mid-DRAIN or in HALTED SHALL return to RUN with counters cleared.

Verification
REQ-034 Load-use: dREN_ID_EX=1, Rt_ID_EX=5, Rs_IF_ID=5, ihit=1 -> enable_PC=0, enable_IF_ID=0, flush_ID_EX=1; stall_cnt +1.
REQ-035 Load to $0: same as REQ-034 with Rt_ID_EX=0, Rs_IF_ID=0 -> all enables 1, no flush.
REQ-036 Data stall: dWEN_EX_MEM=1, dhit=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, all 1 on dhit cycle.
REQ-037 Branch plus load_use plus ihit=0 -> enable_PC=1, flush_IF_ID=1, flush_ID_EX=1.
REQ-038 halt_EX_MEM=1, dhit=1 -> next cycle state=1 with only enable_MEM_WB=1, then state=2, halt=1, cycle_cnt frozen; RST pulse -> state=0, counters 0.
REQ-039 Saturation: preload stall_cnt near all-ones via forced stalls with CNT_W=4 -> stall_cnt holds 15, cycle_cnt wraps 15->0.
